frame_mem_arbiter: RTL
======================

Name: frame_mem_arbiter

Overview:
- Shares the single SDRAM burst command port between the camera write path and the LCD read path of the triple-buffered frame store.
- Sits between the frame writer/reader engines and the SDRAM controller. It sequences one burst at a time and steers data strobes to the owning requester.
- Read has priority to protect the LCD from underflow; a streak limit prevents write starvation.

Parameters:
- ADDR_WIDTH, 21, burst start address width (word address).
- MAX_RD_STREAK, 4, consecutive read grants allowed while a write waits.
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT_DONE (used only with the optional feature).
- LOG_LEVEL, 1, simulation-only message verbosity; no RTL effect.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  reset; synchronous, active-low.
- wr_rq  in  1  write burst request; level, held until wr_ack.
- wr_addr  in  ADDR_WIDTH  write burst address; stable while wr_rq=1.
- wr_ack  out  1  one-cycle pulse: write command accepted by memory.
- wr_done  out  1  one-cycle pulse: write burst finished.
- wr_data_req  out  1  = mem_data_req gated by write ownership.
- rd_rq  in  1  read burst request; level, held until rd_ack.
- rd_addr  in  ADDR_WIDTH  read burst address.
- rd_ack  out  1  one-cycle pulse: read command accepted.
- rd_done  out  1  one-cycle pulse: read burst finished.
- rd_data_valid  out  1  = mem_rd_valid gated by read ownership.
- mem_cmd_valid  out  1  command valid to SDRAM controller.
- mem_cmd_we  out  1  1 = write burst, 0 = read burst.
- mem_cmd_addr  out  ADDR_WIDTH  command address.
- mem_cmd_ready  in  1  controller accepts command when high with valid.
- mem_data_req  in  1  controller strobes a write word.
- mem_rd_valid  in  1  controller presents a read word.
- mem_done  in  1  one-cycle pulse at burst end.
- timeout_err  out  1  sticky watchdog flag (optional feature only; else tied 0).

Behaviour:
- Reset (reset_n=0 at posedge clk): state=IDLE, owner=none, streak=0. All outputs 0, including mem_cmd_addr.
- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE: sample requests. Selection:
  - rd_rq only -> read.
  - wr_rq only -> write.
  - both -> read, unless streak==MAX_RD_STREAK, in which case write.
  - Latch owner, address and we. Go to ISSUE; mem_cmd_valid=1 from the next cycle.
- ISSUE: hold mem_cmd_valid/we/addr stable. On a cycle with mem_cmd_valid & mem_cmd_ready:
  - go to WAIT_DONE;
  - pulse the owner's ack in the following cycle (registered);
  - mem_cmd_valid=0 from the following cycle.
- Streak update on acceptance:
  - read grant with wr_rq high -> streak+1, saturating at MAX_RD_STREAK;
  - write grant -> streak=0;
  - read grant with wr_rq low -> streak=0.
- WAIT_DONE: on mem_done, pulse the owner's done the next cycle, then go to GAP.
- GAP: one idle cycle, owner=none, then IDLE. This guarantees a requester that dropped rq on ack is never re-granted on a stale level.
- Minimum cycle from request to mem_cmd_valid: 1 cycle after rq sampled in IDLE. Back-to-back bursts: at most one command per 3 cycles plus memory latency.
- Strobe steering: wr_data_req and rd_data_valid are combinational from mem_data_req/mem_rd_valid, gated by owner in ISSUE or WAIT_DONE. Strobes arriving with owner=none are dropped.
- mem_done in IDLE, ISSUE or GAP: ignored.
- A request withdrawn before acceptance is illegal; the arbiter still completes the latched burst.
- Reset mid-burst: everything returns to reset values on the same clock edge. No ack/done pulses are emitted for the aborted burst.

Optional Feature:
- Macro ARBITER_TIMEOUT_EN.
- Defined:
  - a counter runs in WAIT_DONE;
  - reaching TIMEOUT_CYCLES without mem_done sets timeout_err (sticky until reset), emits the owner's done pulse and goes to GAP;
  - the counter clears on entry to WAIT_DONE.
- Undefined: no counter; timeout_err tied 0; WAIT_DONE waits indefinitely.

Test Plan:
- Reset then write alone: wr_rq=1, wr_addr=0x00100, mem_cmd_ready=1 -> mem_cmd_valid=1, we=1, addr=0x00100 for one cycle; wr_ack 1 cycle later; mem_done -> wr_done next cycle.
- Simultaneous wr_rq and rd_rq, both held continuously, streak=0 -> grant order R,R,R,R,W,R,R,R,R,W; no two acks ever in the same cycle.
- mem_cmd_ready held 0 for 10 cycles -> mem_cmd_valid, we and addr stable all 10 cycles; ack only after ready=1.
- mem_rd_valid toggling during a write burst -> rd_data_valid stays 0; wr_data_req follows mem_data_req exactly.
- reset_n=0 for one cycle in WAIT_DONE -> next cycle all outputs 0; no wr_done or rd_done emitted; a subsequent request is served normally.
- With ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=16, mem_done never asserted -> timeout_err=1 after 16 cycles in WAIT_DONE; owner done pulses; timeout_err stays 1 until reset.

Source files
------------

// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: shares one SDRAM burst command port between the camera
// write path and the LCD read path. Read wins ties, except that a bounded
// streak of read grants while a write waits forces a write grant.
// Optional feature macro: ARBITER_TIMEOUT_EN adds a WAIT_DONE watchdog that
// sets a sticky timeout_err and completes the burst on expiry.
module frame_mem_arbiter #(
   parameter int unsigned ADDR_WIDTH     = 21,
   parameter int unsigned MAX_RD_STREAK  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned LOG_LEVEL      = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_rq,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   output logic                  wr_ack,
   output logic                  wr_done,
   output logic                  wr_data_req,
   input  logic                  rd_rq,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_ack,
   output logic                  rd_done,
   output logic                  rd_data_valid,
   output logic                  mem_cmd_valid,
   output logic                  mem_cmd_we,
   output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
   input  logic                  mem_cmd_ready,
   input  logic                  mem_data_req,
   input  logic                  mem_rd_valid,
   input  logic                  mem_done,
   output logic                  timeout_err
);

   localparam int unsigned STREAK_W = (MAX_RD_STREAK < 1) ? 1 : $clog2(MAX_RD_STREAK + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_WR, OWN_RD} owner_t;

   state_t                state, state_nx;
   owner_t                owner, owner_nx;
   logic [STREAK_W-1:0]   streak, streak_nx;
   logic                  cmd_valid_nx, cmd_we_nx;
   logic [ADDR_WIDTH-1:0] cmd_addr_nx;
   logic                  wr_ack_nx, rd_ack_nx, wr_done_nx, rd_done_nx;
   logic                  pick_wr_c;
   logic                  streak_max_c;
   logic                  data_phase_c;
   logic                  tmo_hit_c;
   logic                  unused_cfg;

   // LOG_LEVEL only steers simulation messages; it has no hardware effect.
   assign unused_cfg = (LOG_LEVEL != 0) ^ (TIMEOUT_CYCLES != 0);

`ifdef ARBITER_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt;

   assign tmo_hit_c = (state == WAIT_DONE) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   // Watchdog: counts cycles spent in WAIT_DONE, clears on every other state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == WAIT_DONE) tmo_cnt <= tmo_cnt + TMO_W'(1);
         else                    tmo_cnt <= '0;
         if (tmo_hit_c && !mem_done) timeout_err <= 1'b1;
      end
   end
`else
   assign tmo_hit_c   = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign streak_max_c = (streak == STREAK_W'(MAX_RD_STREAK));

   // Strobe steering: only the burst owner sees controller data strobes.
   assign data_phase_c  = (state == ISSUE) || (state == WAIT_DONE);
   assign wr_data_req   = mem_data_req & data_phase_c & (owner == OWN_WR);
   assign rd_data_valid = mem_rd_valid & data_phase_c & (owner == OWN_RD);

   // State and registered-output update.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= IDLE;
         owner         <= OWN_NONE;
         streak        <= '0;
         mem_cmd_valid <= 1'b0;
         mem_cmd_we    <= 1'b0;
         mem_cmd_addr  <= '0;
         wr_ack        <= 1'b0;
         rd_ack        <= 1'b0;
         wr_done       <= 1'b0;
         rd_done       <= 1'b0;
      end else begin
         state         <= state_nx;
         owner         <= owner_nx;
         streak        <= streak_nx;
         mem_cmd_valid <= cmd_valid_nx;
         mem_cmd_we    <= cmd_we_nx;
         mem_cmd_addr  <= cmd_addr_nx;
         wr_ack        <= wr_ack_nx;
         rd_ack        <= rd_ack_nx;
         wr_done       <= wr_done_nx;
         rd_done       <= rd_done_nx;
      end
   end

   // Next-state, grant selection, streak bookkeeping and pulse generation.
   always_comb begin
      state_nx     = state;
      owner_nx     = owner;
      streak_nx    = streak;
      cmd_valid_nx = mem_cmd_valid;
      cmd_we_nx    = mem_cmd_we;
      cmd_addr_nx  = mem_cmd_addr;
      wr_ack_nx    = 1'b0;
      rd_ack_nx    = 1'b0;
      wr_done_nx   = 1'b0;
      rd_done_nx   = 1'b0;
      pick_wr_c    = wr_rq & (~rd_rq | streak_max_c);

      unique case (state)
         IDLE: begin
            if (wr_rq || rd_rq) begin
               owner_nx     = pick_wr_c ? OWN_WR : OWN_RD;
               cmd_we_nx    = pick_wr_c;
               cmd_addr_nx  = pick_wr_c ? wr_addr : rd_addr;
               cmd_valid_nx = 1'b1;
               state_nx     = ISSUE;
            end
         end
         ISSUE: begin
            if (mem_cmd_valid && mem_cmd_ready) begin
               cmd_valid_nx = 1'b0;
               state_nx     = WAIT_DONE;
               if (owner == OWN_WR) begin
                  wr_ack_nx = 1'b1;
                  streak_nx = '0;
               end else begin
                  rd_ack_nx = 1'b1;
                  if (!wr_rq)            streak_nx = '0;
                  else if (!streak_max_c) streak_nx = streak + STREAK_W'(1);
               end
            end
         end
         WAIT_DONE: begin
            if (mem_done || tmo_hit_c) begin
               wr_done_nx = (owner == OWN_WR);
               rd_done_nx = (owner == OWN_RD);
               owner_nx   = OWN_NONE;
               state_nx   = GAP;
            end
         end
         GAP: begin
            owner_nx = OWN_NONE;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule
